vector_mem_wb_stage: RTL and testbench

MEM→WB boundary of the TessiaX64 pipeline. Registers the scalar and vector memory-stage results and control into the W-stage signals consumed by the write-back muxes. Vector loads are gathered as four 16-bit lane reads over a narrow lane-memory port, stalling upstream until all lanes arrive. Ordinary instructions pass through as a plain 1-cycle pipeline register.

---
 rtl/vector_mem_wb_stage.sv | 250 +++++++++++++++++++++++++
 tb/tb_vector_mem_wb_stage.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_mem_wb_stage.sv
// TessiaX64 MEM->WB pipeline register with a 4-lane x 16-bit vector gather over a narrow lane port.
// Optional per-lane ack timeout: define LANE_TIMEOUT_EN.
module vector_mem_wb_stage #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ValidM,
  input  logic                   VectorLoadM,
  input  logic                   MemToRegM,
  input  logic                   VectorMemWriteM,
  input  logic                   RegWriteM,
  input  logic                   VRegWriteM,
  input  logic [3:0]             WriteRegM,
  input  logic [WIDTH-1:0]       ALUOutM,
  input  logic [WIDTH-1:0]       ReadDataM,
  input  logic [3:0][15:0]       VectorALUOutM,
  input  logic [ADDR_W-1:0]      VectorAddrM,
  input  logic                   FlushW,
  output logic                   LaneReq,
  output logic [ADDR_W-1:0]      LaneAddr,
  input  logic [15:0]            LaneRdata,
  input  logic                   LaneAck,
  output logic                   StallM,
  output logic                   ValidW,
  output logic                   RegWriteW,
  output logic                   VRegWriteW,
  output logic                   MemToRegW,
  output logic                   VectorMemWriteW,
  output logic [3:0]             WriteRegW,
  output logic [WIDTH-1:0]       ALUOutW,
  output logic [WIDTH-1:0]       ReadDataW,
  output logic [3:0][15:0]       VectorALUOutW,
  output logic [3:0][15:0]       VectorReadDataW,
  output logic                   VectorLoadErrW
);

  if (TIMEOUT < 1) begin : g_timeout_check
    $error("TIMEOUT must be at least 1");
  end

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_GATHER = 2'd1,
    S_DONE   = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [1:0]          lane_q, lane_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [3:0][15:0]    lane_buf_q, lane_buf_d;
  logic                lane_req_q, lane_req_d;
  logic [ADDR_W-1:0]   lane_addr_q, lane_addr_d;

  logic                valid_w_q, valid_w_d;
  logic                reg_write_w_q, reg_write_w_d;
  logic                vreg_write_w_q, vreg_write_w_d;
  logic                mem_to_reg_w_q, mem_to_reg_w_d;
  logic                vec_mem_write_w_q, vec_mem_write_w_d;
  logic [3:0]          write_reg_w_q, write_reg_w_d;
  logic [WIDTH-1:0]    alu_out_w_q, alu_out_w_d;
  logic [WIDTH-1:0]    read_data_w_q, read_data_w_d;
  logic [3:0][15:0]    vec_alu_out_w_q, vec_alu_out_w_d;
  logic [3:0][15:0]    vec_read_data_w_q, vec_read_data_w_d;

  logic                stall_c;
  logic                valid_in_c;
  logic                lane_adv_c;
  logic [15:0]         lane_data_c;

`ifdef LANE_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [15:0] TIMEOUT_FILL = 16'hDEAD;

  logic [CNT_W-1:0]    tmo_cnt_q, tmo_cnt_d;
  logic                err_q, err_d;
  logic                vec_load_err_w_q, vec_load_err_w_d;
`endif

  // Gather FSM, lane request generation and W-stage capture.
  always_comb begin
    state_d     = state_q;
    lane_d      = lane_q;
    base_d      = base_q;
    lane_buf_d  = lane_buf_q;
    stall_c     = 1'b0;
    lane_adv_c  = 1'b0;
    lane_data_c = LaneRdata;
`ifdef LANE_TIMEOUT_EN
    tmo_cnt_d   = tmo_cnt_q;
    err_d       = err_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (ValidM && VectorLoadM) begin
          stall_c = 1'b1;
          base_d  = VectorAddrM;
          lane_d  = 2'd0;
          state_d = S_GATHER;
`ifdef LANE_TIMEOUT_EN
          tmo_cnt_d = '0;
          err_d     = 1'b0;
`endif
        end
      end
      S_GATHER: begin
        stall_c = 1'b1;
        if (FlushW) begin
          state_d = S_IDLE;
          lane_d  = 2'd0;
        end else begin
          lane_adv_c = LaneAck;
`ifdef LANE_TIMEOUT_EN
          // A silent lane is filled with a marker and the gather moves on.
          if (!LaneAck) begin
            if (tmo_cnt_q == CNT_W'(TIMEOUT - 1)) begin
              lane_adv_c  = 1'b1;
              lane_data_c = TIMEOUT_FILL;
              err_d       = 1'b1;
            end else begin
              tmo_cnt_d = tmo_cnt_q + 1'b1;
            end
          end
`endif
          if (lane_adv_c) begin
            lane_buf_d[lane_q] = lane_data_c;
`ifdef LANE_TIMEOUT_EN
            tmo_cnt_d = '0;
`endif
            if (lane_q == 2'd3) begin
              state_d = S_DONE;
            end else begin
              lane_d = lane_q + 2'd1;
            end
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    lane_req_d  = (state_d == S_GATHER);
    lane_addr_d = lane_req_d ? (base_d + ADDR_W'({lane_d, 1'b0})) : '0;

    valid_in_c        = ValidM & ~FlushW;
    valid_w_d         = 1'b0;
    reg_write_w_d     = 1'b0;
    vreg_write_w_d    = 1'b0;
    mem_to_reg_w_d    = mem_to_reg_w_q;
    vec_mem_write_w_d = vec_mem_write_w_q;
    write_reg_w_d     = write_reg_w_q;
    alu_out_w_d       = alu_out_w_q;
    read_data_w_d     = read_data_w_q;
    vec_alu_out_w_d   = vec_alu_out_w_q;
    vec_read_data_w_d = vec_read_data_w_q;
`ifdef LANE_TIMEOUT_EN
    vec_load_err_w_d  = 1'b0;
`endif

    // Stalled cycles issue a bubble; data registers keep their contents.
    if (!stall_c) begin
      valid_w_d         = valid_in_c;
      reg_write_w_d     = RegWriteM & valid_in_c;
      vreg_write_w_d    = VRegWriteM & valid_in_c;
      mem_to_reg_w_d    = MemToRegM;
      vec_mem_write_w_d = VectorMemWriteM;
      write_reg_w_d     = WriteRegM;
      alu_out_w_d       = ALUOutM;
      read_data_w_d     = ReadDataM;
      vec_alu_out_w_d   = VectorALUOutM;
      if (state_q == S_DONE) begin
        vec_read_data_w_d = lane_buf_q;
`ifdef LANE_TIMEOUT_EN
        vec_load_err_w_d  = err_q & valid_in_c;
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q           <= S_IDLE;
      lane_q            <= 2'd0;
      base_q            <= '0;
      lane_buf_q        <= '0;
      lane_req_q        <= 1'b0;
      lane_addr_q       <= '0;
      valid_w_q         <= 1'b0;
      reg_write_w_q     <= 1'b0;
      vreg_write_w_q    <= 1'b0;
      mem_to_reg_w_q    <= 1'b0;
      vec_mem_write_w_q <= 1'b0;
      write_reg_w_q     <= '0;
      alu_out_w_q       <= '0;
      read_data_w_q     <= '0;
      vec_alu_out_w_q   <= '0;
      vec_read_data_w_q <= '0;
`ifdef LANE_TIMEOUT_EN
      tmo_cnt_q         <= '0;
      err_q             <= 1'b0;
      vec_load_err_w_q  <= 1'b0;
`endif
    end else begin
      state_q           <= state_d;
      lane_q            <= lane_d;
      base_q            <= base_d;
      lane_buf_q        <= lane_buf_d;
      lane_req_q        <= lane_req_d;
      lane_addr_q       <= lane_addr_d;
      valid_w_q         <= valid_w_d;
      reg_write_w_q     <= reg_write_w_d;
      vreg_write_w_q    <= vreg_write_w_d;
      mem_to_reg_w_q    <= mem_to_reg_w_d;
      vec_mem_write_w_q <= vec_mem_write_w_d;
      write_reg_w_q     <= write_reg_w_d;
      alu_out_w_q       <= alu_out_w_d;
      read_data_w_q     <= read_data_w_d;
      vec_alu_out_w_q   <= vec_alu_out_w_d;
      vec_read_data_w_q <= vec_read_data_w_d;
`ifdef LANE_TIMEOUT_EN
      tmo_cnt_q         <= tmo_cnt_d;
      err_q             <= err_d;
      vec_load_err_w_q  <= vec_load_err_w_d;
`endif
    end
  end

  assign StallM          = stall_c;
  assign LaneReq         = lane_req_q;
  assign LaneAddr        = lane_addr_q;
  assign ValidW          = valid_w_q;
  assign RegWriteW       = reg_write_w_q;
  assign VRegWriteW      = vreg_write_w_q;
  assign MemToRegW       = mem_to_reg_w_q;
  assign VectorMemWriteW = vec_mem_write_w_q;
  assign WriteRegW       = write_reg_w_q;
  assign ALUOutW         = alu_out_w_q;
  assign ReadDataW       = read_data_w_q;
  assign VectorALUOutW   = vec_alu_out_w_q;
  assign VectorReadDataW = vec_read_data_w_q;
`ifdef LANE_TIMEOUT_EN
  assign VectorLoadErrW  = vec_load_err_w_q;
`else
  assign VectorLoadErrW  = 1'b0;
`endif

endmodule

// File: tb/tb_vector_mem_wb_stage.sv
// Self-checking bench for vector_mem_wb_stage: directed plan items plus a randomized mix of
// scalar ops and gathers against a lane-memory model and per-instruction expectations.
module tb_vector_mem_wb_stage;
  localparam int unsigned WIDTH   = 8;
  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned TIMEOUT = 15;

  logic clk = 1'b0;
  logic rst;
  logic ValidM, VectorLoadM, MemToRegM, VectorMemWriteM, RegWriteM, VRegWriteM;
  logic [3:0] WriteRegM;
  logic [WIDTH-1:0] ALUOutM, ReadDataM;
  logic [3:0][15:0] VectorALUOutM;
  logic [ADDR_W-1:0] VectorAddrM;
  logic FlushW;
  logic LaneReq;
  logic [ADDR_W-1:0] LaneAddr;
  logic [15:0] LaneRdata;
  logic LaneAck;
  logic StallM, ValidW, RegWriteW, VRegWriteW, MemToRegW, VectorMemWriteW;
  logic [3:0] WriteRegW;
  logic [WIDTH-1:0] ALUOutW, ReadDataW;
  logic [3:0][15:0] VectorALUOutW, VectorReadDataW;
  logic VectorLoadErrW;

  always #5 clk = ~clk;

  vector_mem_wb_stage #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .ValidM(ValidM), .VectorLoadM(VectorLoadM), .MemToRegM(MemToRegM),
    .VectorMemWriteM(VectorMemWriteM), .RegWriteM(RegWriteM), .VRegWriteM(VRegWriteM),
    .WriteRegM(WriteRegM), .ALUOutM(ALUOutM), .ReadDataM(ReadDataM), .VectorALUOutM(VectorALUOutM),
    .VectorAddrM(VectorAddrM), .FlushW(FlushW), .LaneReq(LaneReq), .LaneAddr(LaneAddr),
    .LaneRdata(LaneRdata), .LaneAck(LaneAck), .StallM(StallM), .ValidW(ValidW),
    .RegWriteW(RegWriteW), .VRegWriteW(VRegWriteW), .MemToRegW(MemToRegW),
    .VectorMemWriteW(VectorMemWriteW), .WriteRegW(WriteRegW), .ALUOutW(ALUOutW),
    .ReadDataW(ReadDataW), .VectorALUOutW(VectorALUOutW), .VectorReadDataW(VectorReadDataW),
    .VectorLoadErrW(VectorLoadErrW)
  );

  int checks = 0;
  int errors = 0;

  logic [15:0] lane_mem [logic [15:0]];
  logic [3:0][15:0] exp_vrd;
  logic [15:0] got_addr [$];
  logic [15:0] vl_base;
  int ack_delay, hang_lane, wait_cnt;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    ValidM = 1'b0; VectorLoadM = 1'b0; FlushW = 1'b0;
    MemToRegM = 1'($urandom); VectorMemWriteM = 1'($urandom);
    RegWriteM = 1'($urandom); VRegWriteM = 1'($urandom);
    WriteRegM = 4'($urandom); ALUOutM = WIDTH'($urandom); ReadDataM = WIDTH'($urandom);
    VectorALUOutM = {$urandom, $urandom}; VectorAddrM = ADDR_W'($urandom);
    LaneAck = 1'($urandom); LaneRdata = 16'($urandom);
  endtask

  // Lane memory: acks a request once it has waited ack_delay cycles; never acks the hung lane.
  task automatic respond();
    logic [15:0] off;
    int idx;
    LaneAck = 1'b0;
    LaneRdata = 16'($urandom);
    if (LaneReq) begin
      off = LaneAddr - vl_base;
      idx = int'(off[15:1]);
      if (idx != hang_lane && wait_cnt >= ack_delay - 1) begin
        LaneAck = 1'b1;
        LaneRdata = lane_mem.exists(LaneAddr) ? lane_mem[LaneAddr] : 16'h0000;
        got_addr.push_back(LaneAddr);
        wait_cnt = 0;
      end else begin
        wait_cnt++;
      end
    end
  endtask

  task automatic set_fields(output logic rw, output logic vrw, output logic m2r, output logic vmw,
                            output logic [3:0] wreg, output logic [WIDTH-1:0] alu,
                            output logic [WIDTH-1:0] rd, output logic [3:0][15:0] valu);
    rw = 1'($urandom); vrw = 1'($urandom); m2r = 1'($urandom); vmw = 1'($urandom);
    wreg = 4'($urandom); alu = WIDTH'($urandom); rd = WIDTH'($urandom); valu = {$urandom, $urandom};
    RegWriteM = rw; VRegWriteM = vrw; MemToRegM = m2r; VectorMemWriteM = vmw;
    WriteRegM = wreg; ALUOutM = alu; ReadDataM = rd; VectorALUOutM = valu;
  endtask

  // Present a vector load in M and run until StallM drops or the budget expires.
  task automatic run_vload(input logic [15:0] base, input int dly, input int hang, input int budget,
                           output int stalls, output bit done);
    vl_base = base; ack_delay = dly; hang_lane = hang; wait_cnt = 0;
    got_addr.delete();
    stalls = 0; done = 1'b0;
    ValidM = 1'b1; VectorLoadM = 1'b1; VectorAddrM = base; FlushW = 1'b0;
    for (int c = 0; c < budget; c++) begin
      respond();
      @(negedge clk);
      if (!StallM) begin
        done = 1'b1;
        break;
      end
      stalls++;
      check("stall_bubble_validw", 64'(ValidW), 64'(0));
      next_cycle();
    end
  endtask

  task automatic check_w(input string tag, input logic valid, input logic rw, input logic vrw,
                         input logic m2r, input logic vmw, input logic [3:0] wreg,
                         input logic [WIDTH-1:0] alu, input logic [WIDTH-1:0] rd,
                         input logic [3:0][15:0] valu, input logic err);
    check({tag, "_validw"}, 64'(ValidW), 64'(valid));
    check({tag, "_regwritew"}, 64'(RegWriteW), 64'(rw & valid));
    check({tag, "_vregwritew"}, 64'(VRegWriteW), 64'(vrw & valid));
    check({tag, "_memtoregw"}, 64'(MemToRegW), 64'(m2r));
    check({tag, "_vecmemwritew"}, 64'(VectorMemWriteW), 64'(vmw));
    check({tag, "_writeregw"}, 64'(WriteRegW), 64'(wreg));
    check({tag, "_aluoutw"}, 64'(ALUOutW), 64'(alu));
    check({tag, "_readdataw"}, 64'(ReadDataW), 64'(rd));
    check({tag, "_valuoutw"}, VectorALUOutW, valu);
    check({tag, "_vreaddataw"}, VectorReadDataW, exp_vrd);
    check({tag, "_errw"}, 64'(VectorLoadErrW), 64'(err));
  endtask

  task automatic scalar_op(input bit flush, input logic [WIDTH-1:0] rd_in, input logic [3:0] wreg_in,
                           input logic m2r_in);
    logic rw, vrw, m2r, vmw;
    logic [3:0] wreg;
    logic [WIDTH-1:0] alu, rd;
    logic [3:0][15:0] valu;
    set_fields(rw, vrw, m2r, vmw, wreg, alu, rd, valu);
    ReadDataM = rd_in; WriteRegM = wreg_in; MemToRegM = m2r_in;
    ValidM = 1'b1; VectorLoadM = 1'b0; FlushW = flush;
    LaneAck = 1'($urandom); LaneRdata = 16'($urandom);
    @(negedge clk);
    check("scalar_stallm", 64'(StallM), 64'(0));
    check("scalar_lanereq", 64'(LaneReq), 64'(0));
    next_cycle();
    drive_idle();
    @(negedge clk);
    check_w("scalar", !flush, rw, vrw, m2r_in, vmw, wreg_in, alu, rd_in, valu, 1'b0);
    next_cycle();
  endtask

  task automatic vload_test(input logic [15:0] base, input int dly, input logic [3:0][15:0] vals);
    logic rw, vrw, m2r, vmw;
    logic [3:0] wreg;
    logic [WIDTH-1:0] alu, rd;
    logic [3:0][15:0] valu;
    logic [15:0] a;
    int stalls;
    bit done;
    for (int i = 0; i < 4; i++) begin
      a = base + 16'(2 * i);
      lane_mem[a] = vals[i];
    end
    set_fields(rw, vrw, m2r, vmw, wreg, alu, rd, valu);
    run_vload(base, dly, -1, 64, stalls, done);
    check("vload_done", 64'(done), 64'(1));
    check("vload_stall_cycles", 64'(stalls), 64'(1 + 4 * dly));
    check("vload_addr_count", 64'(got_addr.size()), 64'(4));
    for (int i = 0; i < got_addr.size() && i < 4; i++) begin
      a = base + 16'(2 * i);
      check("vload_lane_addr", 64'(got_addr[i]), 64'(a));
    end
    next_cycle();
    drive_idle();
    exp_vrd = vals;
    @(negedge clk);
    check_w("vload", 1'b1, rw, vrw, m2r, vmw, wreg, alu, rd, valu, 1'b0);
    next_cycle();
  endtask

  task automatic flush_test(input logic [15:0] base);
    logic rw, vrw, m2r, vmw;
    logic [3:0] wreg;
    logic [WIDTH-1:0] alu, rd;
    logic [3:0][15:0] valu;
    logic [15:0] a;
    for (int i = 0; i < 4; i++) begin
      a = base + 16'(2 * i);
      lane_mem[a] = 16'($urandom);
    end
    set_fields(rw, vrw, m2r, vmw, wreg, alu, rd, valu);
    RegWriteM = 1'b1; VRegWriteM = 1'b1;
    vl_base = base; ack_delay = 1; hang_lane = -1; wait_cnt = 0;
    ValidM = 1'b1; VectorLoadM = 1'b1; VectorAddrM = base; FlushW = 1'b0;
    respond();
    @(negedge clk);
    check("flush_idle_stallm", 64'(StallM), 64'(1));
    next_cycle();
    respond();
    @(negedge clk);
    check("flush_lane0_req", 64'(LaneReq), 64'(1));
    next_cycle();
    LaneAck = 1'b0;
    FlushW = 1'b1;
    a = base + 16'd2;
    @(negedge clk);
    check("flush_lane1_req", 64'(LaneReq), 64'(1));
    check("flush_lane1_addr", 64'(LaneAddr), 64'(a));
    check("flush_cycle_stallm", 64'(StallM), 64'(1));
    next_cycle();
    drive_idle();
    @(negedge clk);
    check("flush_after_lanereq", 64'(LaneReq), 64'(0));
    check("flush_after_stallm", 64'(StallM), 64'(0));
    check("flush_after_validw", 64'(ValidW), 64'(0));
    check("flush_after_vregwritew", 64'(VRegWriteW), 64'(0));
    next_cycle();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_validw"}, 64'(ValidW), 64'(0));
    check({tag, "_regwritew"}, 64'(RegWriteW), 64'(0));
    check({tag, "_vregwritew"}, 64'(VRegWriteW), 64'(0));
    check({tag, "_memtoregw"}, 64'(MemToRegW), 64'(0));
    check({tag, "_vecmemwritew"}, 64'(VectorMemWriteW), 64'(0));
    check({tag, "_writeregw"}, 64'(WriteRegW), 64'(0));
    check({tag, "_aluoutw"}, 64'(ALUOutW), 64'(0));
    check({tag, "_readdataw"}, 64'(ReadDataW), 64'(0));
    check({tag, "_valuoutw"}, VectorALUOutW, 64'(0));
    check({tag, "_vreaddataw"}, VectorReadDataW, 64'(0));
    check({tag, "_errw"}, 64'(VectorLoadErrW), 64'(0));
    check({tag, "_lanereq"}, 64'(LaneReq), 64'(0));
    check({tag, "_laneaddr"}, 64'(LaneAddr), 64'(0));
    check({tag, "_stallm"}, 64'(StallM), 64'(0));
  endtask

  initial begin
    logic [3:0][15:0] vals;
    logic [15:0] base, a;
    int stalls, budget;
    bit done;

    rst = 1'b1;
    drive_idle();
    exp_vrd = '0;
    vl_base = '0; ack_delay = 1; hang_lane = -1; wait_cnt = 0;
    #2;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    next_cycle();

    scalar_op(1'b0, 8'hA5, 4'd3, 1'b1);

    vals[0] = 16'd1; vals[1] = 16'd2; vals[2] = 16'd3; vals[3] = 16'd4;
    vload_test(16'h0100, 1, vals);
    check("vload_0100_data", VectorReadDataW, 64'h0004_0003_0002_0001);

    vals = {$urandom, $urandom};
    vload_test(16'hFFFE, 2, vals);

    flush_test(16'($urandom));
    scalar_op(1'b0, WIDTH'($urandom), 4'($urandom), 1'($urandom));

    // Gather stuck on lane 2, then asynchronous reset mid-gather.
    base = 16'($urandom);
    for (int i = 0; i < 4; i++) begin
      a = base + 16'(2 * i);
      lane_mem[a] = 16'($urandom);
    end
`ifdef LANE_TIMEOUT_EN
    budget = 8;
`else
    budget = 43;
`endif
    run_vload(base, 1, 2, budget, stalls, done);
    check("hang_not_done", 64'(done), 64'(0));
    check("hang_stall_cycles", 64'(stalls), 64'(budget));
    check("hang_lanereq", 64'(LaneReq), 64'(1));
    drive_idle();
    rst = 1'b1;
    #1;
    exp_vrd = '0;
    check_all_zero("midreset");
    @(negedge clk);
    rst = 1'b0;
    next_cycle();
    @(negedge clk);
    check("post_reset_lanereq", 64'(LaneReq), 64'(0));
    check("post_reset_validw", 64'(ValidW), 64'(0));
    check("post_reset_stallm", 64'(StallM), 64'(0));
    next_cycle();

`ifdef LANE_TIMEOUT_EN
    begin
      logic rw, vrw, m2r, vmw;
      logic [3:0] wreg;
      logic [WIDTH-1:0] alu, rd;
      logic [3:0][15:0] valu;
      base = 16'($urandom);
      vals = {$urandom, $urandom};
      for (int i = 0; i < 4; i++) begin
        a = base + 16'(2 * i);
        lane_mem[a] = vals[i];
      end
      set_fields(rw, vrw, m2r, vmw, wreg, alu, rd, valu);
      run_vload(base, 1, 2, 80, stalls, done);
      check("timeout_done", 64'(done), 64'(1));
      check("timeout_stall_cycles", 64'(stalls), 64'(3 + TIMEOUT + 1));
      next_cycle();
      drive_idle();
      vals[2] = 16'hDEAD;
      exp_vrd = vals;
      @(negedge clk);
      check_w("timeout", 1'b1, rw, vrw, m2r, vmw, wreg, alu, rd, valu, 1'b1);
      next_cycle();
    end
`endif

    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 1) == 0) begin
        scalar_op($urandom_range(0, 3) == 0, WIDTH'($urandom), 4'($urandom), 1'($urandom));
      end else begin
        vals = {$urandom, $urandom};
        vload_test(16'($urandom), int'($urandom_range(1, 3)), vals);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
